// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Register file with per-register pending (scoreboard) bits, two
//            registered read ports with write bypass, and a sequential clear.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_ready,
    output logic              rs2_ready
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic              rs1_ready_q, rs1_ready_d;
    logic              rs2_ready_q, rs2_ready_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        pend_d      = pend_q;
        rs1_data_d  = '0;
        rs2_data_d  = '0;
        rs1_ready_d = 1'b0;
        rs2_ready_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                data_d[cnt_q[ADDR_W-1:0]] = '0;
                pend_d[cnt_q[ADDR_W-1:0]] = 1'b0;
                cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                if (cnt_q[ADDR_W-1:0] == LAST_IDX) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (wr_en) begin
                    data_d[wr_addr] = wr_data;
                    pend_d[wr_addr] = 1'b0;
                end
                // Claim is applied after the write so it wins on a shared address.
                if (claim_en) begin
                    pend_d[claim_addr] = 1'b1;
                end
                // Reading the next-state arrays gives write bypass and same-cycle ready.
                rs1_data_d  = data_d[rs1_addr];
                rs2_data_d  = data_d[rs2_addr];
                rs1_ready_d = ~pend_d[rs1_addr];
                rs2_ready_d = ~pend_d[rs2_addr];
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            rs1_ready_q <= 1'b0;
            rs2_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            pend_q      <= pend_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            rs1_ready_q <= rs1_ready_d;
            rs2_ready_q <= rs2_ready_d;
        end
    end

    assign busy      = (state_q == ST_CLEAR);
    assign rs1_data  = rs1_data_q;
    assign rs2_data  = rs2_data_q;
    assign rs1_ready = rs1_ready_q;
    assign rs2_ready = rs2_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed and random stimulus against a behavioural register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clr_req = 1'b0;
    logic              busy;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              claim_en = 1'b0;
    logic [ADDR_W-1:0] claim_addr = '0;
    logic [ADDR_W-1:0] rs1_addr = '0;
    logic [ADDR_W-1:0] rs2_addr = '0;
    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic              rs1_ready, rs2_ready;

    regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (clr_req),
        .busy       (busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs1_ready  (rs1_ready),
        .rs2_ready  (rs2_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: register contents, pending flags, clear progress.
    logic [DATA_W-1:0] m_data [DEPTH];
    bit                m_pend [DEPTH];
    bit                m_busy = 1'b0;
    int                m_idx  = 0;
    logic [DATA_W-1:0] e_rs1_data, e_rs2_data;
    bit                e_rs1_ready, e_rs2_ready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_busy = 1'b1;
            m_idx  = 0;
            e_rs1_data = '0; e_rs2_data = '0;
            e_rs1_ready = 1'b0; e_rs2_ready = 1'b0;
        end else if (m_busy) begin
            m_data[m_idx] = '0;
            m_pend[m_idx] = 1'b0;
            m_idx++;
            if (m_idx == DEPTH) m_busy = 1'b0;
            e_rs1_data = '0; e_rs2_data = '0;
            e_rs1_ready = 1'b0; e_rs2_ready = 1'b0;
        end else begin
            if (wr_en) begin
                m_data[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (claim_en) m_pend[claim_addr] = 1'b1;
            e_rs1_data  = m_data[rs1_addr];
            e_rs2_data  = m_data[rs2_addr];
            e_rs1_ready = !m_pend[rs1_addr];
            e_rs2_ready = !m_pend[rs2_addr];
            if (clr_req) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_eq("busy",      busy,      m_busy);
        check_eq("rs1_data",  rs1_data,  e_rs1_data);
        check_eq("rs1_ready", rs1_ready, e_rs1_ready);
        check_eq("rs2_data",  rs2_data,  e_rs2_data);
        check_eq("rs2_ready", rs2_ready, e_rs2_ready);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; clr_req = 1'b0; wr_en = 1'b0; claim_en = 1'b0;
    endtask

    // Steps until busy drops; returns how many post-edge samples showed busy=1.
    task automatic count_busy(input int already, output int n);
        n = already;
        for (int i = 0; i < 20 && busy; i++) begin
            step();
            if (busy) n++;
        end
        if (busy) check_eq("busy_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int nb;
        for (int i = 0; i < DEPTH; i++) begin m_data[i] = '0; m_pend[i] = 1'b0; end

        // Reset one cycle, then the full clear.
        #1;
        reset = 1'b1;
        step();
        check_eq("reset_busy", busy, 1);
        idle_inputs();
        count_busy(1, nb);
        check_eq("reset_busy_len", nb, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            rs1_addr = ADDR_W'(a); rs2_addr = ADDR_W'(DEPTH - 1 - a);
            step();
            check_eq("clr_zero", rs1_data, 16'h0000);
            check_eq("clr_ready", rs1_ready, 1);
        end

        // Write then read, and same-cycle bypass.
        wr_en = 1'b1; wr_addr = 3; wr_data = 16'hBEEF; step();
        wr_en = 1'b1; wr_addr = 5; wr_data = 16'h1234;
        rs1_addr = 3; rs2_addr = 5; step();
        check_eq("r3_read", rs1_data, 16'hBEEF);
        check_eq("r3_ready", rs1_ready, 1);
        check_eq("r5_bypass", rs2_data, 16'h1234);
        idle_inputs();

        // Claim / write / claim+write on R2.
        claim_en = 1'b1; claim_addr = 2; step();
        idle_inputs(); rs1_addr = 2; step();
        check_eq("r2_pending", rs1_ready, 0);
        wr_en = 1'b1; wr_addr = 2; wr_data = 16'h00AA; step();
        idle_inputs(); step();
        check_eq("r2_wr_data", rs1_data, 16'h00AA);
        check_eq("r2_wr_ready", rs1_ready, 1);
        wr_en = 1'b1; wr_addr = 2; wr_data = 16'h0055;
        claim_en = 1'b1; claim_addr = 2; step();
        check_eq("r2_cw_data", rs1_data, 16'h0055);
        check_eq("r2_cw_ready", rs1_ready, 0);
        idle_inputs();

        // Clear request with writes/claims attempted while busy.
        wr_en = 1'b1; wr_addr = 1; wr_data = 16'h7777; step();
        wr_en = 1'b0; clr_req = 1'b1; step();
        check_eq("clr_busy", busy, 1);
        wr_en = 1'b1; wr_addr = 1; wr_data = 16'h5A5A;
        claim_en = 1'b1; claim_addr = 6;
        count_busy(1, nb);
        check_eq("clr_busy_len", nb, DEPTH);
        idle_inputs(); rs1_addr = 1; rs2_addr = 6; step();
        check_eq("r1_cleared", rs1_data, 16'h0000);
        check_eq("r6_not_claimed", rs2_ready, 1);

        // Reset in the middle of a clear restarts it.
        clr_req = 1'b1; step();
        clr_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1; step();
        reset = 1'b0;
        count_busy(1, nb);
        check_eq("restart_busy_len", nb, DEPTH);

        // Both ports on the same address.
        wr_en = 1'b1; wr_addr = 7; wr_data = 16'hFFFF; step();
        idle_inputs(); rs1_addr = 7; rs2_addr = 7; step();
        check_eq("r7_p1", rs1_data, 16'hFFFF);
        check_eq("r7_p2", rs2_data, 16'hFFFF);
        check_eq("r7_rdy", rs1_ready & rs2_ready, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            clr_req    = ($urandom_range(0, 39) == 0);
            wr_en      = $urandom_range(0, 1);
            wr_addr    = ADDR_W'($urandom);
            wr_data    = DATA_W'($urandom);
            claim_en   = ($urandom_range(0, 2) == 0);
            claim_addr = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom);
            rs1_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom);
            rs2_addr   = ($urandom_range(0, 3) == 0) ? rs1_addr : ADDR_W'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 3, register address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk and reset.
REQ-004 SHALL have ports, in order:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clr_req  in  1  request a full clear of registers and scoreboard.
- busy  out  1  clear sequence in progress.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- claim_en  in  1  mark a destination register pending (instruction issued).
- claim_addr  in  ADDR_W  register to mark pending.
- rs1_addr, rs2_addr  in  ADDR_W  read addresses.
- rs1_data, rs2_data  out  DATA_W  registered read data.
- rs1_ready, rs2_ready  out  1  registered "operand not pending" flags.

Function
REQ-005 SHALL hold DEPTH x DATA_W data registers and DEPTH pending bits.
REQ-006 SHALL implement an FSM with states IDLE and CLEAR, plus a clear counter of ADDR_W+1 bits.
REQ-007 In CLEAR, SHALL zero data[cnt] and pending[cnt] each cycle and increment cnt; after entry DEPTH-1 is cleared, SHALL go to IDLE (exactly DEPTH cycles in CLEAR).
REQ-008 In IDLE, clr_req=1 SHALL enter CLEAR on the next edge with cnt=0; clr_req during CLEAR SHALL be ignored (no restart).
REQ-009 busy SHALL be 1 while in CLEAR, 0 in IDLE.
REQ-010 While busy=1, wr_en and claim_en SHALL be ignored; rs*_data SHALL register 0 and rs*_ready SHALL register 0.
REQ-011 In IDLE, wr_en=1 SHALL write wr_data to data[wr_addr] and clear pending[wr_addr] on the edge.
REQ-012 In IDLE, claim_en=1 SHALL set pending[claim_addr] on the edge.
REQ-013 On wr_en and claim_en to the same address in the same cycle, data SHALL be written and pending SHALL end set (claim wins).
REQ-014 Read latency SHALL be one cycle: rsN_data/rsN_ready at edge k reflect rsN_addr sampled at edge k.
REQ-015 Write bypass: if wr_en=1 and wr_addr==rsN_addr in the sampling cycle, rsN_data SHALL register wr_data, not the old contents.
REQ-016 rsN_ready SHALL register !pending[rsN_addr] as updated by the same-cycle write/claim (write-only to that address gives 1, any claim to that address gives 0).
REQ-017 Both read ports SHALL be independent; equal addresses on both ports SHALL return identical values.
REQ-018 No arithmetic on data; addresses SHALL span all DEPTH entries with no out-of-range case.

Reset
REQ-019 reset=1 SHALL force state CLEAR, cnt=0, busy=1, rs*_data=0, rs*_ready=0 on the edge, overriding every other input.
REQ-020 reset mid-CLEAR SHALL restart the clear at cnt=0; after reset deasserts, busy SHALL stay 1 for exactly DEPTH cycles.
REQ-021 After the clear completes, all registers SHALL read 0 with ready=1.

Verification
REQ-022 Reset 1 cycle, release -> busy=1 for 8 cycles then 0; every read returns 0x0000, ready=1.
REQ-023 After clear, write R3=0xBEEF; next cycle read rs1=R3 -> rs1_data=0xBEEF, ready=1; same-cycle write R5=0x1234 with rs2_addr=5 -> rs2_data=0x1234 one edge later.
REQ-024 claim R2, read R2 -> ready=0; write R2=0x00AA -> next read R2 gives 0x00AA, ready=1; simultaneous claim+write R2=0x0055 -> data 0x0055, ready=0.
REQ-025 R1=0x7777 set, clr_req pulse -> busy=1 for 8 cycles, writes/claims during busy ignored, R1 then reads 0x0000.
REQ-026 reset asserted at cnt=4 of a clear -> clear restarts; busy stays 1 for exactly 8 cycles after release.
REQ-027 rs1_addr=rs2_addr=7 with R7=0xFFFF -> both ports return 0xFFFF, ready=1.
